// File: rtl/case_stim_driver.sv
// rtl/case_stim_driver.sv - sweeps 16 selector vectors into a 2-bit decoder and captures its output
// Optional golden compare and mismatch_cnt port: define CASE_STIM_GOLDEN_CHECK_EN.
module case_stim_driver #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [1:0]  a_o,
  output logic [1:0]  b_o,
  input  logic        dut_out_i,
  output logic        busy,
  output logic        sample_o,
  output logic [15:0] resp_bits,
  output logic        done,
`ifdef CASE_STIM_GOLDEN_CHECK_EN
  output logic        aborted,
  output logic [4:0]  mismatch_cnt
`else
  output logic        aborted
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [3:0] settle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      settle    <= 4'd0;
      a_o       <= 2'd0;
      b_o       <= 2'd0;
      busy      <= 1'b0;
      sample_o  <= 1'b0;
      resp_bits <= 16'h0000;
      done      <= 1'b0;
      aborted   <= 1'b0;
`ifdef CASE_STIM_GOLDEN_CHECK_EN
      mismatch_cnt <= 5'd0;
`endif
    end else begin
      sample_o <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 4'd0;
            resp_bits <= 16'h0000;
            aborted   <= 1'b0;
`ifdef CASE_STIM_GOLDEN_CHECK_EN
            mismatch_cnt <= 5'd0;
`endif
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          a_o    <= idx[1:0];
          b_o    <= idx[3:2];
          settle <= 4'(SETTLE_CYCLES - 1);
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (settle == 4'd0) begin
            sample_o <= 1'b1;
            state    <= CAPTURE;
          end else begin
            settle <= settle - 4'd1;
          end
        end
        CAPTURE: begin
          // The bit is written even when abort lands in this same cycle.
          resp_bits[idx] <= dut_out_i;
`ifdef CASE_STIM_GOLDEN_CHECK_EN
          if ((dut_out_i != a_o[0]) && (mismatch_cnt != 5'd31))
            mismatch_cnt <= mismatch_cnt + 5'd1;
`endif
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (idx == 4'd15) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_stim_driver.sv
// tb/tb_case_stim_driver.sv - directed bench for case_stim_driver (SETTLE_CYCLES=2 and 1)
module tb_case_stim_driver;

  logic        clk = 1'b0;
  logic        rst, start, abort, start2;
  logic [1:0]  a_o, b_o, a2, b2;
  logic        dut_in, dut2;
  logic        busy, sample_o, done, aborted;
  logic        busy2, sample2, done2, aborted2;
  logic [15:0] resp_bits, resp2;
  logic        mode;
`ifdef CASE_STIM_GOLDEN_CHECK_EN
  logic [4:0]  mismatch_cnt, mismatch2;
`endif

  int nchecks = 0;
  int npass   = 0;

  always #5 clk = ~clk;

  assign dut_in = mode ? 1'b1 : a_o[0];
  assign dut2   = a2[0];

  case_stim_driver #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .dut_out_i(dut_in), .busy(busy),
    .sample_o(sample_o), .resp_bits(resp_bits), .done(done),
`ifdef CASE_STIM_GOLDEN_CHECK_EN
    .aborted(aborted), .mismatch_cnt(mismatch_cnt)
`else
    .aborted(aborted)
`endif
  );

  case_stim_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .a_o(a2), .b_o(b2), .dut_out_i(dut2), .busy(busy2),
    .sample_o(sample2), .resp_bits(resp2), .done(done2),
`ifdef CASE_STIM_GOLDEN_CHECK_EN
    .aborted(aborted2), .mismatch_cnt(mismatch2)
`else
    .aborted(aborted2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Cycle 0 is the cycle in which start is high; cycle c follows the c-th edge after it.
  task automatic sweep(input int max, input int start_at, input int abort_at, input int rst_at,
                       output int done_cyc, output int ndone, output int nsamp,
                       output int first_samp, output int bad_gap, output int bad_vec,
                       output int busy_fall);
    int c, prev;
    done_cyc = -1; ndone = 0; nsamp = 0; first_samp = -1;
    bad_gap = 0; bad_vec = 0; busy_fall = -1; prev = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c <= max) begin
      start = (c == start_at);
      abort = (c == abort_at);
      rst   = (c == rst_at);
      if (sample_o) begin
        if ({b_o, a_o} != 4'(nsamp)) bad_vec++;
        if (nsamp == 0) first_samp = c;
        else if (c - prev != 4) bad_gap++;
        prev = c;
        nsamp++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!busy && busy_fall < 0) busy_fall = c;
      tick();
      c++;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int dc, nd, ns, fs, bg, bv, bf, c, d2;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; mode = 1'b0;
    repeat (3) tick();
    chk("rst_a", 32'(a_o), 32'h0);
    chk("rst_b", 32'(b_o), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sample", 32'(sample_o), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_aborted", 32'(aborted), 32'h0);
    chk("rst_resp", 32'(resp_bits), 32'h0);
`ifdef CASE_STIM_GOLDEN_CHECK_EN
    chk("rst_mm", 32'(mismatch_cnt), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // nominal sweep, decoder output follows a_o[0]
    sweep(70, -1, -1, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("nom_done_cyc", 32'(dc), 32'd65);
    chk("nom_ndone", 32'(nd), 32'd1);
    chk("nom_nsamp", 32'(ns), 32'd16);
    chk("nom_first_samp", 32'(fs), 32'd4);
    chk("nom_bad_gap", 32'(bg), 32'd0);
    chk("nom_bad_vec", 32'(bv), 32'd0);
    chk("nom_busy_fall", 32'(bf), 32'd66);
    chk("nom_resp", 32'(resp_bits), 32'hAAAA);
`ifdef CASE_STIM_GOLDEN_CHECK_EN
    chk("nom_mm", 32'(mismatch_cnt), 32'd0);
`endif

    // decoder stuck at 1
    mode = 1'b1;
    sweep(70, -1, -1, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("one_done_cyc", 32'(dc), 32'd65);
    chk("one_resp", 32'(resp_bits), 32'hFFFF);
`ifdef CASE_STIM_GOLDEN_CHECK_EN
    chk("one_mm", 32'(mismatch_cnt), 32'd8);
`endif

    // abort in the CAPTURE cycle of vector 5 (cycle 1 + 5*4 + 3)
    sweep(40, -1, 24, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("abt_resp", 32'(resp_bits), 32'h003F);
    chk("abt_aborted", 32'(aborted), 32'h1);
    chk("abt_ndone", 32'(nd), 32'd0);
    chk("abt_nsamp", 32'(ns), 32'd6);
    chk("abt_busy_fall", 32'(bf), 32'd25);

    // new start clears resp_bits; abort before any capture
    sweep(20, -1, 2, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("abt2_resp", 32'(resp_bits), 32'h0000);
    chk("abt2_aborted", 32'(aborted), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clr_aborted", 32'(aborted), 32'h0);

    sweep(20, -1, 2, -1, dc, nd, ns, fs, bg, bv, bf);
    mode = 1'b0;
    sweep(70, -1, -1, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("restart_aborted", 32'(aborted), 32'h0);
    chk("restart_resp", 32'(resp_bits), 32'hAAAA);

    // reset during WAIT of vector 9 (DRIVE at cycle 37)
    sweep(50, -1, -1, 38, dc, nd, ns, fs, bg, bv, bf);
    chk("mrst_done", 32'(dc), 32'hFFFF_FFFF);
    chk("mrst_outs", {22'd0, a_o, b_o, busy, sample_o, done, aborted, 2'b00},
        32'h0);
    chk("mrst_resp", 32'(resp_bits), 32'h0);
    chk("mrst_nsamp", 32'(ns), 32'd9);

    // re-pulsed start mid-sweep is ignored; sweep starts from vector 0
    sweep(70, 20, -1, -1, dc, nd, ns, fs, bg, bv, bf);
    chk("rep_done_cyc", 32'(dc), 32'd65);
    chk("rep_bad_vec", 32'(bv), 32'd0);
    chk("rep_resp", 32'(resp_bits), 32'hAAAA);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort", 32'(aborted), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // SETTLE_CYCLES=1 instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    c = 1; d2 = -1;
    while (c <= 60) begin
      if (done2 && d2 < 0) d2 = c;
      tick();
      c++;
    end
    chk("s1_done_cyc", 32'(d2), 32'd49);
    chk("s1_resp", 32'(resp2), 32'hAAAA);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
